// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Adds two WIDTH-bit operands four bits per cycle through an
//               external combinational 4-bit ripple adder. Each cycle the
//               controller presents one nibble slice and the registered carry,
//               then captures the sum nibble and the carry-out.
//               Optional feature macro: NIBBLE_SERIAL_SUB_EN (adds sub_i port;
//               sub_i=1 computes op_a - op_b, cout_o=1 means no borrow).
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             cin_i,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic [3:0]       adder_a_o,
    output logic [3:0]       adder_b_o,
    output logic             adder_cin_o,
    input  logic [3:0]       adder_sum_i,
    input  logic             adder_cout_i
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               w_accept;
    logic               w_first_carry;
    logic [3:0]         w_b_nib;
    logic [WIDTH-1:0]   w_sum_next;

`ifdef NIBBLE_SERIAL_SUB_EN
    logic               sub_q, sub_d;

    // Subtraction feeds the inverted B nibble and forces the initial carry
    // so that A + ~B + 1 = A - B.
    assign w_first_carry = sub_i ? 1'b1 : cin_i;
    assign w_b_nib       = sub_q ? ~b_sr_q[3:0] : b_sr_q[3:0];
`else
    assign w_first_carry = cin_i;
    assign w_b_nib       = b_sr_q[3:0];
`endif

    // A new operation may only be accepted while not running.
    assign w_accept = start_i && ((state_q == IDLE) || (state_q == DONE));

    // Sum nibble from the adder enters at the top; earlier nibbles move down.
    assign w_sum_next = (sum_sr_q >> 4) | {adder_sum_i, {(WIDTH-4){1'b0}}};

    // Adder inputs are parked at zero outside RUN so the adder stays quiet.
    // adder_cin_o comes only from the carry register, never from adder_cout_i.
    assign adder_a_o   = (state_q == RUN) ? a_sr_q[3:0] : 4'd0;
    assign adder_b_o   = (state_q == RUN) ? w_b_nib     : 4'd0;
    assign adder_cin_o = (state_q == RUN) ? carry_q     : 1'b0;

    assign busy_o   = (state_q == RUN);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;
    assign cout_o   = cout_q;

    // Next-state and datapath update: load on accept, shift one nibble per RUN cycle.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        result_d = result_q;
        cout_d   = cout_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
`ifdef NIBBLE_SERIAL_SUB_EN
        sub_d    = sub_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (w_accept) begin
                    state_d = RUN;
                    a_sr_d  = op_a_i;
                    b_sr_d  = op_b_i;
                    carry_d = w_first_carry;
                    cnt_d   = '0;
`ifdef NIBBLE_SERIAL_SUB_EN
                    sub_d   = sub_i;
`endif
                end
            end
            RUN: begin
                carry_d  = adder_cout_i;
                sum_sr_d = w_sum_next;
                a_sr_d   = a_sr_q >> 4;
                b_sr_d   = b_sr_q >> 4;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_NIB) begin
                    // Result becomes visible only on completion.
                    result_d = w_sum_next;
                    cout_d   = adder_cout_i;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_q    <= sub_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencing controller that adds two WIDTH-bit operands four bits per cycle using the team's external 4-bit ripple adder (full_adder_4bit). It feeds one nibble slice and a registered carry to the adder each cycle, consumes the adder's sum/carry-out, and assembles the full-width result. It sits directly upstream and downstream of the 4-bit adder in the datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8
NIBBLES, WIDTH/4, derived localparam: number of adder passes per operation

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new addition; sampled only in IDLE or DONE
op_a  input  WIDTH  operand A, captured on accepted start
op_b  input  WIDTH  operand B, captured on accepted start
cin  input  1  initial carry-in, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result/cout become valid
result  output  WIDTH  registered sum; held until next accepted start
cout  output  1  registered final carry-out; held with result
adder_a  output  4  nibble of A to adder
adder_b  output  4  nibble of B to adder
adder_cin  output  1  carry into adder
adder_sum  input  4  sum from adder (combinational)
adder_cout  input  1  carry-out from adder (combinational)

Behaviour:
- Interface: one clock (clk); reset rst_n asynchronous, active-low.
- Reset: state=IDLE; busy=0, done=0, result=0, cout=0; operand/carry regs and nibble counter 0; adder_a/adder_b/adder_cin=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> latch op_a, op_b into shift regs, cin into carry_reg, counter=0, go RUN.
- RUN: adder_a=a_sr[3:0], adder_b=b_sr[3:0], adder_cin=carry_reg. Each cycle: carry_reg<=adder_cout; result shift reg shifts right 4, adder_sum enters top nibble; a_sr/b_sr shift right 4; counter++. After cycle with counter==NIBBLES-1: cout<=adder_cout, go DONE.
- DONE: done=1 for exactly this cycle; busy=0. Next state IDLE, or RUN if start=1 (back-to-back accepted, operands latched as in IDLE).
- Latency: start sampled at edge N -> busy high N+1..N+NIBBLES, done high in cycle N+NIBBLES+1 (16-bit: 4 RUN cycles).
- start while busy: ignored, no effect on in-flight operation or held operands.
- adder_a/adder_b/adder_cin driven 0 outside RUN (no toggling on idle adder).
- result/cout updated only at operation end as seen externally: visible result changes only on the done cycle (shift into internal reg, copy to result on RUN->DONE); prior result held during RUN.
- Carry chain across nibbles only through carry_reg; no combinational path from adder_cout to adder_cin.
- Reset mid-operation: abort immediately, all outputs to reset values, no done pulse.
- Arithmetic: {cout,result} = op_a + op_b + cin, modulo 2^(WIDTH+1).

Optional Feature:
NIBBLE_SERIAL_SUB_EN
- Defined: extra input port sub (1 bit, captured on accepted start). sub=1 -> adder_b = ~b_sr[3:0], initial carry_reg forced 1 (cin ignored); result = op_a - op_b mod 2^WIDTH, cout=1 means no borrow. sub=0 identical to base.
- Undefined: no sub port; addition only.

Test Plan:
- WIDTH=16, op_a=0x1234, op_b=0x4321, cin=0, start 1 cycle -> busy 4 cycles, done pulse on 5th cycle after start edge, result=0x5555, cout=0.
- op_a=0xFFFF, op_b=0x0001, cin=0 -> carry through all nibbles: result=0x0000, cout=1; adder_cin observed 0,1,1,1 over RUN.
- op_a=0xFFFF, op_b=0x0000, cin=1 -> result=0x0000, cout=1; then start held high on done cycle with 0x0001+0x0001 -> next result 0x0002, cout=0, no idle gap.
- start pulsed with 0x1111+0x1111, start re-asserted with 0xAAAA+0x5555 during RUN -> ignored; result=0x2222, single done pulse.
- rst_n low during 2nd RUN cycle -> busy/done/result/cout=0 immediately, adder ports 0; new start after release completes correctly.
- NIBBLE_SERIAL_SUB_EN defined: sub=1, 0x0005-0x0007 -> result=0xFFFE, cout=0; sub=1, 0x0010-0x0001 -> result=0x000F, cout=1.
